// File: rtl/ysyx_24100029_ifu_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100029_ifu_prefetch_pkg
// Description : Shared AXI encodings, reset fetch address and the layout of
//               one prefetch-buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100029_ifu_prefetch_pkg;

    localparam logic [2:0]  SIZE_4B          = 3'b010;
    localparam logic [1:0]  BURST_INCR       = 2'b01;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

    // One buffered fetch: {pc, inst, err} packs to 65 bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/ysyx_24100029_ifu_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100029_ifu_prefetch_if
// Description : Pipeline-side (redirect/stall/decode) and AXI read-side
//               signals of the prefetching fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_24100029_ifu_prefetch_if #(
    parameter int ID_W = 4
);
    // pipeline control
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            stall;
    // decode side
    logic            valid;
    logic            ready;
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic            inst_err;
    // AXI AR channel
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    // AXI R channel
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    // Fetch unit view
    modport master (
        input  redirect, redirect_pc, stall, ready,
        input  arready, rvalid, rdata, rresp, rlast, rid,
        output valid, pc, inst, inst_err,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

    // Pipeline + memory view
    modport slave (
        output redirect, redirect_pc, stall, ready,
        output arready, rvalid, rdata, rresp, rlast, rid,
        input  valid, pc, inst, inst_err,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24100029_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100029_sync_fifo
// Description : Register-based synchronous FIFO with flush and occupancy.
//               Head data is zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100029_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             flush,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full,
    output logic      [AW:0]      count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push && !full) r_wptr <= r_wptr + 1'b1;
            if (pop && !empty) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset; only pointer-qualified entries are ever read.
    always_ff @(posedge clock) begin
        if (push && !full) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

    // Occupancy and head read from registered state only.
    always_comb begin
        count = r_wptr - r_rptr;
        empty = (count == '0);
        full  = (count == (AW+1)'(DEPTH));
        rdata = empty ? '0 : r_mem[r_rptr[AW-1:0]];
    end
endmodule
`default_nettype wire

// File: rtl/ysyx_24100029_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100029_ifu_prefetch
// Description : Instruction fetch with prefetch buffer. Issues single-beat
//               AXI reads ahead of decode, reserving buffer space at issue so
//               rready can stay high. Redirects flush the buffer and discard
//               beats still owed for the old stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100029_ifu_prefetch
    import ysyx_24100029_ifu_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          ID_W            = 4
) (
    input wire logic                      clock,
    input wire logic                      reset,
    ysyx_24100029_ifu_prefetch_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          r_arvalid;
    logic [31:0]   r_araddr;
    logic [31:0]   r_fpc;
    logic [31:0]   r_rpc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    logic          w_beat;
    logic          w_drop_beat;
    logic          w_push;
    logic          w_pop;
    logic          w_ar_free;
    logic          w_issue;
    logic [CW-1:0] w_inflight_after;
    logic [CW-1:0] w_drop_after;
    logic [CW-1:0] w_count_after;
    logic [CW:0]   w_credit_used;
    logic          w_unused_ok;

    // Beat disposal and issue decision, using counter values after this
    // cycle's beat, push, pop and flush have been applied.
    always_comb begin
        w_beat           = bus.rvalid;
        w_drop_beat      = w_beat && (r_drop_cnt != '0);
        // A beat landing with a redirect belongs to the old stream.
        w_push           = w_beat && !w_drop_beat && !bus.redirect;
        w_pop            = !w_fifo_empty && bus.ready;
        w_inflight_after = r_inflight - CW'(w_beat);
        w_drop_after     = bus.redirect ? w_inflight_after
                                        : (r_drop_cnt - CW'(w_drop_beat));
        w_count_after    = bus.redirect ? '0
                                        : (w_fifo_count + CW'(w_push) - CW'(w_pop));
        // Kept reads still owed plus buffered entries must leave a free slot.
        w_credit_used    = {1'b0, w_inflight_after - w_drop_after} + {1'b0, w_count_after};
        w_ar_free        = !r_arvalid || bus.arready;
        w_issue          = w_ar_free && !bus.stall && !bus.redirect
                        && (w_inflight_after < CW'(MAX_OUTSTANDING))
                        && (w_credit_used < (CW+1)'(FIFO_DEPTH));
        w_push_entry.pc   = r_rpc;
        w_push_entry.inst = bus.rdata;
        w_push_entry.err  = (bus.rresp != RESP_OKAY);
    end

    // AR channel, fetch/response pcs and the outstanding/discard counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_fpc      <= RESET_PC;
            r_rpc      <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            // A raised request holds its address until accepted.
            if (w_ar_free) r_arvalid <= w_issue;
            if (w_issue)   r_araddr  <= r_fpc;
            r_fpc      <= bus.redirect ? bus.redirect_pc
                                       : (w_issue ? r_fpc + 32'd4 : r_fpc);
            r_rpc      <= bus.redirect ? bus.redirect_pc
                                       : (w_push ? r_rpc + 32'd4 : r_rpc);
            r_inflight <= w_inflight_after + CW'(w_issue);
            r_drop_cnt <= w_drop_after;
        end
    end

    ysyx_24100029_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (bus.redirect),
        .push  (w_push),
        .wdata (w_push_entry),
        .pop   (w_pop),
        .rdata (w_head),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    assign bus.valid    = !w_fifo_empty;
    assign bus.pc       = w_head.pc;
    assign bus.inst     = w_head.inst;
    assign bus.inst_err = w_head.err;
    assign bus.arvalid  = r_arvalid;
    assign bus.araddr   = r_araddr;
    assign bus.arid     = ID_W'(0);
    assign bus.arlen    = 8'd0;
    assign bus.arsize   = SIZE_4B;
    assign bus.arburst  = BURST_INCR;
    assign bus.rready   = 1'b1;

    // Single-beat, single-ID reads: rlast and rid carry no information.
    // Full is never reached on push thanks to the credit check.
    assign w_unused_ok  = ^{bus.rlast, bus.rid, w_fifo_full};
endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100029_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24100029_ifu_prefetch
// Description : Bench for the prefetching fetch unit. Memory slave and
//               pipeline are modelled per stream "epoch": a redirect opens a
//               new epoch, only beats requested in the current epoch may
//               reach decode, and decode must see consecutive pcs from the
//               redirect target with inst/err derived from the pc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100029_ifu_prefetch;
    import ysyx_24100029_ifu_prefetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h3000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_24100029_ifu_prefetch_if #(.ID_W(4)) bus ();

    ysyx_24100029_ifu_prefetch #(
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .ID_W            (4)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } rq_t;

    rq_t         slave_q[$];
    int          total = 0, bad = 0;
    int          cyc = 0, epoch = 0, pend_epoch = 0, outst = 0, occ = 0, n_pops = 0;
    logic [31:0] exp_pc, next_fetch, last_pop_pc;
    logic [3:0]  err_sel;
    bit          seen_err;
    int          p_arready, p_ready, p_rvalid, p_redir, p_stall, min_delay, max_delay;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return a[5:2] == err_sel;
    endfunction

    function automatic bit chance(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic set_knobs(input int par, input int pr, input int prv, input int pred,
                             input int pst, input int dmin, input int dmax);
        p_arready = par; p_ready = pr; p_rvalid = prv; p_redir = pred;
        p_stall = pst; min_delay = dmin; max_delay = dmax;
    endtask

    // One clock: account for the handshakes the coming edge performs, then
    // check the DUT at the following negedge and pick the next inputs.
    task automatic cycle();
        bit          acc, beat, pop, rd, free_prev, arv_prev, stall_prev, herr;
        logic [31:0] ara_prev, rt, hpc, off;
        rq_t         e;
        acc        = bus.arvalid && bus.arready;
        beat       = bus.rvalid;
        pop        = bus.valid && bus.ready;
        rd         = bus.redirect;
        rt         = bus.redirect_pc;
        free_prev  = !bus.arvalid || bus.arready;
        arv_prev   = bus.arvalid;
        ara_prev   = bus.araddr;
        stall_prev = bus.stall;
        hpc        = bus.pc;
        herr       = bus.inst_err;
        if (acc)
            slave_q.push_back('{ara_prev, pend_epoch,
                                cyc + int'($urandom_range(max_delay, min_delay))});
        if (beat && slave_q.size() > 0) begin
            e = slave_q.pop_front();
            outst--;
            if (!rd && e.epoch == epoch) occ++;
        end
        if (rd) begin
            occ = 0; epoch++; exp_pc = rt; next_fetch = rt;
        end else if (pop) begin
            occ--; n_pops++; last_pop_pc = hpc; exp_pc = exp_pc + 32'd4;
            if (hpc == 32'h3000_0004 && herr) seen_err = 1'b1;
        end

        @(negedge clock);
        cyc++;

        if (free_prev && (stall_prev || rd)) begin
            total++;
            if (bus.arvalid !== 1'b0) begin
                bad++;
                $display("FAIL ar_blocked: arvalid=%b required 0 (stall=%b redirect=%b)",
                         bus.arvalid, stall_prev, rd);
            end
        end
        if (bus.arvalid && free_prev) begin
            pend_epoch = epoch;
            outst++;
            total++;
            if (bus.araddr !== next_fetch) begin
                bad++;
                $display("FAIL araddr: got %h required %h", bus.araddr, next_fetch);
            end
            next_fetch = next_fetch + 32'd4;
        end
        if (arv_prev && !free_prev) begin
            total++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== ara_prev) begin
                bad++;
                $display("FAIL ar_hold: arvalid=%b araddr=%h required 1 %h",
                         bus.arvalid, bus.araddr, ara_prev);
            end
        end
        total++;
        if (outst > MAXO) begin
            bad++;
            $display("FAIL outstanding: got %0d required <= %0d", outst, MAXO);
        end
        total++;
        if (bus.valid !== (occ > 0) || occ > DEPTH) begin
            bad++;
            $display("FAIL valid: got %b required %b (entries %0d)", bus.valid, occ > 0, occ);
        end
        total++;
        if (bus.valid) begin
            if (bus.pc !== exp_pc || bus.inst !== inst_of(exp_pc) || bus.inst_err !== err_of(exp_pc)) begin
                bad++;
                $display("FAIL head: got pc=%h inst=%h err=%b required pc=%h inst=%h err=%b",
                         bus.pc, bus.inst, bus.inst_err, exp_pc, inst_of(exp_pc), err_of(exp_pc));
            end
        end else if (bus.pc !== 32'd0 || bus.inst !== 32'd0 || bus.inst_err !== 1'b0) begin
            bad++;
            $display("FAIL empty_head: got pc=%h inst=%h err=%b required zeros",
                     bus.pc, bus.inst, bus.inst_err);
        end
        total++;
        if (bus.rready !== 1'b1 || bus.arid !== 4'd0 || bus.arlen !== 8'd0 ||
            bus.arsize !== 3'b010 || bus.arburst !== 2'b01) begin
            bad++;
            $display("FAIL ar_const: rready=%b arid=%h arlen=%h arsize=%b arburst=%b required 1 0 0 010 01",
                     bus.rready, bus.arid, bus.arlen, bus.arsize, bus.arburst);
        end

        bus.arready = chance(p_arready);
        bus.ready   = chance(p_ready);
        bus.stall   = chance(p_stall);
        bus.redirect = chance(p_redir);
        off = $urandom_range(255, 0);
        if ($urandom_range(3, 0) == 0) bus.redirect_pc = 32'hFFFF_FFF0 + ((off & 32'd3) << 2);
        else                           bus.redirect_pc = RPC + (off << 2);
        if (slave_q.size() > 0 && slave_q[0].due <= cyc && chance(p_rvalid)) begin
            bus.rvalid = 1'b1;
            bus.rdata  = inst_of(slave_q[0].addr);
            bus.rresp  = err_of(slave_q[0].addr) ? 2'b10 : 2'b00;
        end else begin
            bus.rvalid = 1'b0;
            bus.rdata  = $urandom;
            bus.rresp  = 2'b00;
        end
        bus.rlast = 1'b1;
        bus.rid   = 4'($urandom_range(15, 0));
    endtask

    task automatic do_reset(input logic [3:0] es);
        @(negedge clock);
        reset = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0; bus.ready = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
        bus.rlast = 1'b0; bus.rid = '0;
        repeat (2) @(negedge clock);
        total++;
        if (bus.arvalid !== 1'b0 || bus.valid !== 1'b0 || bus.pc !== 32'd0 ||
            bus.inst !== 32'd0 || bus.inst_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: arvalid=%b valid=%b pc=%h inst=%h err=%b required all 0",
                     bus.arvalid, bus.valid, bus.pc, bus.inst, bus.inst_err);
        end
        slave_q.delete();
        err_sel = es; occ = 0; outst = 0; epoch++; n_pops = 0; seen_err = 1'b0;
        exp_pc = RPC; next_fetch = RPC; last_pop_pc = '0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_knobs(0, 0, 100, 0, 0, 0, 0);
        do_reset(4'($urandom_range(15, 0)));
        cycle();
        total++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== RPC) begin
            bad++;
            $display("FAIL first_ar: arvalid=%b araddr=%h required 1 %h", bus.arvalid, bus.araddr, RPC);
        end
    endtask

    task automatic test_stream();
        set_knobs(100, 100, 100, 0, 0, 0, 0);
        do_reset(4'($urandom_range(15, 0)));
        bus.arready = 1'b1; bus.ready = 1'b1;
        repeat (40) cycle();
        total++;
        if (n_pops < 15 || last_pop_pc !== RPC + 32'(4 * (n_pops - 1))) begin
            bad++;
            $display("FAIL stream_seq: pops=%0d last_pc=%h required >=15 and %h",
                     n_pops, last_pop_pc, RPC + 32'(4 * (n_pops - 1)));
        end
    endtask

    task automatic test_full();
        int k;
        set_knobs(100, 0, 100, 0, 0, 0, 0);
        do_reset(4'($urandom_range(15, 0)));
        bus.arready = 1'b1;
        repeat (30) cycle();
        total++;
        if (bus.arvalid !== 1'b0 || slave_q.size() != 0 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL full_idle: arvalid=%b inflight=%0d valid=%b required 0 0 1",
                     bus.arvalid, slave_q.size(), bus.valid);
        end
        set_knobs(100, 100, 100, 0, 100, 0, 0);
        bus.stall = 1'b1; bus.ready = 1'b1;
        k = 0;
        while (bus.valid && k < 12) begin cycle(); k++; end
        total++;
        if (n_pops != DEPTH || last_pop_pc !== RPC + 32'hC || bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL full_count: pops=%0d last_pc=%h required %0d %h",
                     n_pops, last_pop_pc, DEPTH, RPC + 32'hC);
        end
    endtask

    task automatic test_redirect_inflight();
        int k;
        set_knobs(100, 0, 100, 0, 0, 8, 8);
        do_reset(4'($urandom_range(15, 0)));
        bus.arready = 1'b1;
        k = 0;
        while (slave_q.size() < 2 && k < 20) begin cycle(); k++; end
        total++;
        if (slave_q.size() != 2) begin
            bad++;
            $display("FAIL redir_setup: inflight=%0d required 2", slave_q.size());
        end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h3000_0100;
        set_knobs(100, 100, 100, 0, 0, 0, 0);
        k = 0;
        while (n_pops < 1 && k < 40) begin cycle(); k++; end
        total++;
        if (n_pops < 1 || last_pop_pc !== 32'h3000_0100) begin
            bad++;
            $display("FAIL redir_pc: pops=%0d first_pc=%h required 30000100", n_pops, last_pop_pc);
        end
    endtask

    task automatic test_ar_hold();
        int k;
        set_knobs(0, 100, 100, 0, 0, 0, 0);
        do_reset(4'($urandom_range(15, 0)));
        cycle();
        cycle();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h3000_0200;
        repeat (3) cycle();
        total++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== RPC) begin
            bad++;
            $display("FAIL ar_stable: arvalid=%b araddr=%h required 1 %h", bus.arvalid, bus.araddr, RPC);
        end
        set_knobs(100, 100, 100, 0, 0, 0, 0);
        bus.arready = 1'b1;
        k = 0;
        while (n_pops < 1 && k < 30) begin cycle(); k++; end
        total++;
        if (n_pops < 1 || last_pop_pc !== 32'h3000_0200) begin
            bad++;
            $display("FAIL hold_redir_pc: pops=%0d first_pc=%h required 30000200", n_pops, last_pop_pc);
        end
    endtask

    task automatic test_err();
        set_knobs(100, 100, 100, 0, 0, 0, 0);
        do_reset(4'd1);
        bus.arready = 1'b1; bus.ready = 1'b1;
        repeat (20) cycle();
        total++;
        if (!seen_err) begin
            bad++;
            $display("FAIL err_entry: inst_err at pc 30000004 seen=%b required 1", seen_err);
        end
    endtask

    task automatic test_stall();
        int k;
        set_knobs(100, 0, 100, 0, 0, 3, 3);
        do_reset(4'($urandom_range(15, 0)));
        bus.arready = 1'b1;
        k = 0;
        while (!(occ >= 2 && slave_q.size() >= 1) && k < 30) begin cycle(); k++; end
        total++;
        if (!(occ >= 2 && slave_q.size() >= 1)) begin
            bad++;
            $display("FAIL stall_setup: entries=%0d inflight=%0d required >=2 >=1", occ, slave_q.size());
        end
        set_knobs(100, 100, 100, 0, 100, 3, 3);
        bus.stall = 1'b1; bus.ready = 1'b1;
        k = 0;
        while ((bus.valid || slave_q.size() > 0 || bus.arvalid) && k < 30) begin cycle(); k++; end
        total++;
        if (bus.valid !== 1'b0 || slave_q.size() != 0 || n_pops < 3) begin
            bad++;
            $display("FAIL stall_drain: valid=%b inflight=%0d pops=%0d required 0 0 >=3",
                     bus.valid, slave_q.size(), n_pops);
        end
        set_knobs(100, 100, 100, 0, 0, 0, 0);
        bus.stall = 1'b0;
        cycle();
        total++;
        if (bus.arvalid !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume: arvalid=%b required 1", bus.arvalid);
        end
    endtask

    task automatic test_random();
        set_knobs(60, 60, 70, 4, 15, 0, 4);
        do_reset(4'($urandom_range(15, 0)));
        repeat (600) cycle();
        total++;
        if (n_pops < 20) begin
            bad++;
            $display("FAIL random_progress: pops=%0d required >=20", n_pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_inflight();
        test_ar_hold();
        test_err();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
